calc_operand_entry: RTL and testbench

Operand-entry controller for the two-operand 4-bit calculator. It conditions the raw push-buttons and sequences the user through entering operand A, choosing add or subtract, and entering operand B. It then holds `num1`, `num2` and `op_selected` stable for the downstream registered add/subtract ALU. It also drives that ALU's active-high `clear` input and flags when the ALU result is valid.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/button_conditioner.sv | 67 ++++++
 rtl/calc_operand_entry.sv | 157 +++++++++++++++
 tb/tb_calc_operand_entry.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the two-operand 4-bit calculator front end:
//   - entry_state_t : operand-entry FSM states (3-bit, encodings fixed because
//                     they are shown directly on the state LEDs)
//   - OP_ADD/OP_SUB : encodings of the op_selected line driven to the ALU
//   - DEFAULT_*     : default parameter values for the entry controller
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_OP = 3'd1,
        ENTER_B  = 3'd2,
        WAIT_ALU = 3'd3,
        SHOW     = 3'd4
    } entry_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage : calc_pkg

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns one raw, bouncy, asynchronous push-button into a single-cycle press
// pulse in the clk domain.
//   clk      : system clock, rising edge
//   clear_n  : asynchronous active-low reset
//   btn      : raw button level, active-high, asynchronous to clk
//   press    : one-cycle pulse per accepted 0->1 transition of the button
//
// Pipeline: two-flop synchronizer -> debounce counter -> registered rise
// detector. For a clean edge the pulse appears 2 + DEBOUNCE_CYCLES + 1 clock
// edges after the raw transition. Releases are debounced the same way but do
// not generate a pulse.
// -----------------------------------------------------------------------------
module button_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btn,
    output logic press
);

    // The counter only has to count up to DEBOUNCE_CYCLES-1: the sample that
    // would make it reach DEBOUNCE_CYCLES flips the level instead.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             level;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here is updated with <= so that all flops sample
    // the values from before the edge; blocking assignments would let sync_out
    // see the new sync_meta in the same edge and collapse the synchronizer.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync_meta  <= btn;
            sync_out   <= sync_meta;
            level_prev <= level;
            press      <= level & ~level_prev;

            if (sync_out == level) begin
                // Any sample agreeing with the accepted level restarts the
                // stability window, which is what rejects bounce.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_out;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : button_conditioner

// File: rtl/calc_operand_entry.sv
// -----------------------------------------------------------------------------
// calc_operand_entry
// Operand-entry controller for the two-operand calculator. Conditions the
// three push-buttons and walks the user through A, op, B, then holds the
// operands steady for the registered add/subtract ALU downstream.
//   clk          : system clock, rising edge
//   clear_n      : asynchronous active-low reset
//   sw_value     : operand switches, sampled only on accepted enter presses
//   btn_enter    : raw enter button (active-high, asynchronous)
//   btn_op       : raw add/subtract toggle button (active-high, asynchronous)
//   btn_reset    : raw user-clear button (active-high, asynchronous)
//   num1, num2   : operands A and B to the ALU
//   op_selected  : 0 = add, 1 = subtract
//   alu_clear    : registered one-cycle clear pulse to the ALU
//   result_ready : ALU output corresponds to the current operands
//   state_out    : current FSM state encoding for the LEDs
// -----------------------------------------------------------------------------
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] sw_value,
    input  logic             btn_enter,
    input  logic             btn_op,
    input  logic             btn_reset,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic             op_selected,
    output logic             alu_clear,
    output logic             result_ready,
    output logic [2:0]       state_out
);

    logic enter_press;
    logic op_press;
    logic reset_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (clk),
        .clear_n (clear_n),
        .btn     (btn_enter),
        .press   (enter_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op (
        .clk     (clk),
        .clear_n (clear_n),
        .btn     (btn_op),
        .press   (op_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
        .clk     (clk),
        .clear_n (clear_n),
        .btn     (btn_reset),
        .press   (reset_press)
    );

    entry_state_t     state_q, state_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic             op_q, op_d;
    logic             ready_q, ready_d;
    logic             clear_q, clear_d;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ENTER_A;
            num1_q  <= '0;
            num2_q  <= '0;
            op_q    <= OP_ADD;
            ready_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            clear_q <= clear_d;
        end
    end

    // Priority is reset > enter > op. Presses that the current state does not
    // consume are simply dropped; nothing is queued.
    always_comb begin
        // NOTE: every signal written below gets a hold value first, so paths
        // that do not assign it keep the register value instead of inferring
        // a latch.
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        op_d    = op_q;
        ready_d = ready_q;
        clear_d = 1'b0;

        if (reset_press) begin
            state_d = ENTER_A;
            num1_d  = '0;
            num2_d  = '0;
            op_d    = OP_ADD;
            ready_d = 1'b0;
            clear_d = 1'b1;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    if (enter_press) begin
                        num1_d  = sw_value;
                        state_d = ENTER_OP;
                    end
                end
                ENTER_OP: begin
                    // Enter wins over a simultaneous toggle.
                    if (enter_press) begin
                        state_d = ENTER_B;
                    end else if (op_press) begin
                        op_d = ~op_q;
                    end
                end
                ENTER_B: begin
                    if (enter_press) begin
                        num2_d  = sw_value;
                        state_d = WAIT_ALU;
                    end
                end
                WAIT_ALU: begin
                    // One cycle for the ALU to register the new operands, so
                    // result_ready rises together with a valid ALU output.
                    state_d = SHOW;
                    ready_d = 1'b1;
                end
                SHOW: begin
                    if (enter_press) begin
                        state_d = ENTER_A;
                        ready_d = 1'b0;
                        op_d    = OP_ADD;
                    end
                end
                default: begin
                    state_d = ENTER_A;
                end
            endcase
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign op_selected  = op_q;
    assign result_ready = ready_q;
    assign alu_clear    = clear_q;
    assign state_out    = state_q;

endmodule : calc_operand_entry

// File: tb/tb_calc_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_operand_entry
// Directed bench for calc_operand_entry with DEBOUNCE_CYCLES = 4. A tiny
// registered add/subtract ALU stands in for the downstream datapath so the
// result handshake can be checked against a real result.
// -----------------------------------------------------------------------------
module tb_calc_operand_entry;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         clear_n;
    logic [W-1:0] sw_value;
    logic         btn_enter;
    logic         btn_op;
    logic         btn_reset;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         op_selected;
    logic         alu_clear;
    logic         result_ready;
    logic [2:0]   state_out;

    logic [W-1:0] alu_out;

    int checks = 0;
    int errors = 0;

    calc_operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) u_dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .sw_value     (sw_value),
        .btn_enter    (btn_enter),
        .btn_op       (btn_op),
        .btn_reset    (btn_reset),
        .num1         (num1),
        .num2         (num2),
        .op_selected  (op_selected),
        .alu_clear    (alu_clear),
        .result_ready (result_ready),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    // Downstream registered ALU: add when op is 0, subtract when 1.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)       alu_out <= '0;
        else if (alu_clear) alu_out <= '0;
        else if (op_selected) alu_out <= num1 - num2;
        else                alu_out <= num1 + num2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A clean press: held long enough to be accepted, then released and the
    // release allowed to settle before the next action.
    task automatic press_enter(input logic [W-1:0] v);
        sw_value  = v;
        btn_enter = 1'b1;
        cycles(12);
        btn_enter = 1'b0;
        cycles(12);
    endtask

    task automatic press_op();
        btn_op = 1'b1;
        cycles(12);
        btn_op = 1'b0;
        cycles(12);
    endtask

    // User clear: waits for alu_clear, checks the cleared outputs there and
    // counts how many cycles alu_clear is high over the whole press.
    task automatic press_reset_checked(input string tag);
        bit found;
        int highs;
        found = 1'b0;
        highs = 0;
        btn_reset = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (alu_clear) found = 1'b1;
        end
        check({tag, "_clear_seen"}, found, 1);
        if (found) highs = 1;
        check({tag, "_state"}, state_out, 0);
        check({tag, "_num1"}, num1, 0);
        check({tag, "_num2"}, num2, 0);
        check({tag, "_op"}, op_selected, 0);
        check({tag, "_ready"}, result_ready, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) btn_reset = 1'b0;
            if (alu_clear) highs++;
        end
        check({tag, "_clear_width"}, highs, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n;

        clear_n   = 1'b0;
        sw_value  = '0;
        btn_enter = 1'b0;
        btn_op    = 1'b0;
        btn_reset = 1'b0;
        cycles(3);
        check("rst_state", state_out, 0);
        check("rst_num1", num1, 0);
        check("rst_num2", num2, 0);
        check("rst_op", op_selected, 0);
        check("rst_clear", alu_clear, 0);
        check("rst_ready", result_ready, 0);
        clear_n = 1'b1;
        cycles(3);

        // Full sequence: 5 - 3 = 2.
        press_enter(4'd5);
        check("seq_a_state", state_out, 1);
        check("seq_a_num1", num1, 5);
        press_op();
        check("seq_op_toggle", op_selected, 1);
        check("seq_op_state", state_out, 1);
        press_enter(4'd9);
        check("seq_b_entry_state", state_out, 2);
        sw_value  = 4'd3;
        btn_enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (state_out == 3'd3) found = 1'b1;
        end
        check("seq_wait_alu_reached", found, 1);
        check("seq_num2_at_e", num2, 3);
        check("seq_ready_low_at_e", result_ready, 0);
        @(negedge clk);
        check("seq_show_state", state_out, 4);
        check("seq_ready_at_e1", result_ready, 1);
        check("seq_alu_result", alu_out, 2);
        btn_enter = 1'b0;
        cycles(12);
        check("seq_ready_held", result_ready, 1);
        check("seq_num1_held", num1, 5);
        check("seq_num2_held", num2, 3);
        press_enter(4'd0);
        check("seq_back_state", state_out, 0);
        check("seq_back_op", op_selected, 0);
        check("seq_back_ready", result_ready, 0);
        check("seq_back_num1_kept", num1, 5);

        // Op press ignored in ENTER_A.
        press_op();
        check("ign_op_a_state", state_out, 0);
        check("ign_op_a_op", op_selected, 0);

        // Bounce: 2-cycle chatter never survives 4 stable samples.
        sw_value = 4'hC;
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1;
            cycles(2);
            btn_enter = 1'b0;
            cycles(2);
        end
        check("bounce_no_advance", state_out, 0);
        btn_enter = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            n++;
            if (state_out != 3'd0) found = 1'b1;
        end
        // Press pulse 7 edges after the stable edge, consumed on the 8th.
        check("bounce_latency", n, 8);
        cycles(20);
        check("bounce_single_press", state_out, 1);
        check("bounce_num1", num1, 4'hC);
        btn_enter = 1'b0;
        cycles(12);

        // Enter + op together in ENTER_OP: enter wins, toggle dropped.
        sw_value  = 4'd1;
        btn_enter = 1'b1;
        btn_op    = 1'b1;
        cycles(12);
        btn_enter = 1'b0;
        btn_op    = 1'b0;
        cycles(12);
        check("simul_eo_state", state_out, 2);
        check("simul_eo_op", op_selected, 0);

        // User clear mid-entry: num1=9, op=1, in ENTER_B.
        press_reset_checked("clr_prev");
        press_enter(4'd9);
        press_op();
        press_enter(4'd4);
        check("clr_pre_state", state_out, 2);
        check("clr_pre_num1", num1, 9);
        check("clr_pre_op", op_selected, 1);
        press_reset_checked("clr_mid");

        // Reset + enter together: reset wins.
        press_enter(4'd7);
        check("simul_re_pre", state_out, 1);
        sw_value  = 4'd8;
        btn_enter = 1'b1;
        btn_reset = 1'b1;
        cycles(12);
        btn_enter = 1'b0;
        btn_reset = 1'b0;
        cycles(12);
        check("simul_re_state", state_out, 0);
        check("simul_re_num1", num1, 0);

        // Reach SHOW with 2 + 6, then op press must be ignored.
        press_enter(4'd2);
        press_enter(4'd1);
        press_enter(4'd6);
        check("show_state", state_out, 4);
        check("show_alu", alu_out, 8);
        press_op();
        check("ign_op_show_state", state_out, 4);
        check("ign_op_show_op", op_selected, 0);
        check("ign_op_show_num2", num2, 6);

        // Asynchronous reset during SHOW, away from a clock edge.
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check("arst_state", state_out, 0);
        check("arst_num1", num1, 0);
        check("arst_num2", num2, 0);
        check("arst_op", op_selected, 0);
        check("arst_ready", result_ready, 0);
        check("arst_clear", alu_clear, 0);
        sw_value  = 4'hA;
        btn_enter = 1'b1;
        #1;
        clear_n = 1'b1;
        cycles(12);
        check("arst_held_press_state", state_out, 1);
        check("arst_held_press_num1", num1, 4'hA);
        btn_enter = 1'b0;
        cycles(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_calc_operand_entry
